// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and sizing helpers for the FIFO read-side stream adapter.
package fifo_rd_stream_pkg;

  localparam int MAX_RD_LATENCY     = 4;
  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef logic [DEFAULT_DATA_WIDTH-1:0] fifo_word_t;

  // Width of a pointer that indexes 0..depth-1.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Width of a counter that holds 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fifo_rd_stream_buf.sv
// Circular output buffer: push/pop ports, occupancy count and a head word
// selected from registered storage.
module fifo_rd_stream_buf
  import fifo_rd_stream_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 3,
  localparam int PTR_W      = ptr_width(DEPTH),
  localparam int OCC_W      = cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [OCC_W-1:0]      occ,
  output logic                  not_empty
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // NOTE: the storage is reset on purpose: it is only a handful of words and the
  // head must read as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign occ       = occ_q;
  assign not_empty = (occ_q != '0);

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read port to valid/ready stream adapter with credit-based popping.
// Optional beat counter port beat_cnt when FIFO_RD_STREAM_CNT_EN is defined.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int BUF_DEPTH  = RD_LATENCY + 2
) (
  input  logic                  rd_clk,
  input  logic                  rst,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_rd,
  input  logic                  fifo_empty,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  output logic [31:0]           beat_cnt
`endif
);

  localparam int OCC_W  = cnt_width(BUF_DEPTH);
  localparam int CRED_W = cnt_width(BUF_DEPTH + MAX_RD_LATENCY);

  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [OCC_W-1:0]      occ;
  logic [CRED_W-1:0]     credit_used;
  logic                  capture;
  logic                  xfer;

  // Words already committed = buffered + still returning from the FIFO.
  always_comb begin
    credit_used = CRED_W'(occ);
    for (int i = 0; i < RD_LATENCY; i++) begin
      credit_used = credit_used + CRED_W'(vld_q[i]);
    end
    rd_en = rst && !fifo_empty && (credit_used < CRED_W'(BUF_DEPTH));
    vld_d    = vld_q << 1;
    vld_d[0] = rd_en;
  end

  always_ff @(posedge rd_clk or negedge rst) begin
    if (!rst) vld_q <= '0;
    else      vld_q <= vld_d;
  end

  assign capture = vld_q[RD_LATENCY-1];
  assign xfer    = m_valid && m_ready;

  fifo_rd_stream_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_buf (
    .clk       (rd_clk),
    .rst_n     (rst),
    .push      (capture),
    .push_data (data_rd),
    .pop       (xfer),
    .head_data (m_data),
    .occ       (occ),
    .not_empty (m_valid)
  );

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [31:0] beat_cnt_q, beat_cnt_d;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (xfer) beat_cnt_d = beat_cnt_q + 32'd1;
  end

  always_ff @(posedge rd_clk or negedge rst) begin
    if (!rst) beat_cnt_q <= '0;
    else      beat_cnt_q <= beat_cnt_d;
  end

  assign beat_cnt = beat_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench: a queue-based FIFO model feeds the DUT, expected words are
// queued in issue order and a monitor compares every stream handshake.
module tb_fifo_rd_stream;
  import fifo_rd_stream_pkg::*;

  localparam int L   = 3;
  localparam int BUF = L + 2;

  logic        rd_clk = 1'b0;
  logic        rst    = 1'b0;
  logic        rd_en;
  fifo_word_t  data_rd = '0;
  logic        fifo_empty = 1'b1;
  fifo_word_t  m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
`ifdef FIFO_RD_STREAM_CNT_EN
  logic [31:0] beat_cnt;
`endif

  fifo_rd_stream #(
    .DATA_WIDTH (8),
    .RD_LATENCY (L),
    .BUF_DEPTH  (BUF)
  ) dut (
    .rd_clk     (rd_clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .data_rd    (data_rd),
    .fifo_empty (fifo_empty),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready)
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    .beat_cnt   (beat_cnt)
`endif
  );

  always #5 rd_clk = ~rd_clk;

  fifo_word_t fifo_q [$];
  fifo_word_t exp_q  [$];
  int  rdy_mode   = 1;   // 0: never ready, 1: always ready, 2: random 50%
  bit  empty_rand = 1'b0;
  int  pops_total = 0;
  int  outst      = 0;
  int  beat_model = 0;
  int  n_checks   = 0;
  int  n_fail     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input fifo_word_t w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic wait_drain(input int max_cyc, input string name);
    int c = 0;
    while (exp_q.size() != 0 && c < max_cyc) begin
      @(negedge rd_clk);
      c++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // FIFO model: pop on rd_en, return the word L cycles later on data_rd.
  initial begin
    fifo_word_t pipe [L];
    logic re;
    for (int i = 0; i < L; i++) pipe[i] = '0;
    forever begin
      @(negedge rd_clk);
      re = rd_en;
      @(posedge rd_clk);
      #1;
      for (int i = L - 1; i > 0; i--) pipe[i] = pipe[i-1];
      if (re && rst && fifo_q.size() > 0) pipe[0] = fifo_q.pop_front();
      else                                pipe[0] = 8'($urandom);
      data_rd    = pipe[L-1];
      m_ready    = (rdy_mode == 2) ? ($urandom % 2 == 1) : (rdy_mode == 1);
      fifo_empty = (fifo_q.size() == 0) || (empty_rand && ($urandom % 3 == 0));
    end
  end

  // Monitor: stream ordering, stall stability and credit bound.
  initial begin
    bit         prev_stall = 1'b0;
    fifo_word_t prev_data  = '0;
    forever begin
      @(negedge rd_clk);
      if (!rst) begin
        outst      = 0;
        beat_model = 0;
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        check("hold_valid", 64'(m_valid), 64'd1);
        check("hold_data",  64'(m_data),  64'(prev_data));
      end
      if (rd_en) begin
        check("rd_en_while_empty", 64'(fifo_empty), 64'd0);
        pops_total++;
        outst++;
      end
      if (m_valid && m_ready) begin
        outst--;
        beat_model++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL stream_extra: got word %0h, expected no word", m_data);
        end else begin
          check("stream_data", 64'(m_data), 64'(exp_q.pop_front()));
        end
      end
      check("credit_bound", 64'(outst <= BUF), 64'd1);
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  initial begin
    int first, last, cnt, p0;

    // Reset and idle
    repeat (3) @(negedge rd_clk);
    check("reset_rd_en",   64'(rd_en),   64'd0);
    check("reset_m_valid", 64'(m_valid), 64'd0);
    check("reset_m_data",  64'(m_data),  64'd0);
`ifdef FIFO_RD_STREAM_CNT_EN
    check("reset_beat_cnt", 64'(beat_cnt), 64'd0);
`endif
    @(posedge rd_clk);
    #2 rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge rd_clk);
      check("idle_rd_en",   64'(rd_en),   64'd0);
      check("idle_m_valid", 64'(m_valid), 64'd0);
      check("idle_m_data",  64'(m_data),  64'd0);
    end

    // Single word: rd_en in cycle 0, m_valid only in cycle L+1
    @(negedge rd_clk);
    push_word(8'hA5);
    for (int k = 0; k <= L + 3; k++) begin
      @(negedge rd_clk);
      check("single_rd_en",   64'(rd_en),   64'(k == 0));
      check("single_m_valid", 64'(m_valid), 64'(k == L + 1));
    end
    check("single_drained", 64'(exp_q.size()), 64'd0);

    // Streaming: 16 back-to-back beats
    @(negedge rd_clk);
    for (int i = 0; i < 16; i++) push_word(8'(i));
    first = -1; last = -1; cnt = 0;
    for (int c = 0; c < L + 30; c++) begin
      @(negedge rd_clk);
      if (m_valid && m_ready) begin
        cnt++;
        if (first < 0) first = c;
        last = c;
      end
    end
    check("stream_count",      64'(cnt),              64'd16);
    check("stream_contiguous", 64'(last - first + 1), 64'd16);
    check("stream_drained",    64'(exp_q.size()),     64'd0);

    // Backpressure: pops stop at BUF, head holds
    @(negedge rd_clk);
    rdy_mode = 0;
    @(negedge rd_clk);
    p0 = pops_total;
    for (int i = 0; i < 8; i++) push_word(8'(i));
    repeat (20) @(negedge rd_clk);
    check("bp_pops", 64'(pops_total - p0), 64'(BUF));
    for (int i = 0; i < 5; i++) begin
      @(negedge rd_clk);
      check("bp_rd_en",   64'(rd_en),   64'd0);
      check("bp_m_valid", 64'(m_valid), 64'd1);
      check("bp_m_data",  64'(m_data),  64'h00);
    end
    rdy_mode = 1;
    wait_drain(100, "bp_drained");

    // Random ready and random empty, 1000 words
    @(negedge rd_clk);
    rdy_mode   = 2;
    empty_rand = 1'b1;
    for (int i = 0; i < 1000; i++) push_word(8'($urandom));
    wait_drain(20000, "random_drained");
    empty_rand = 1'b0;
    rdy_mode   = 1;
    repeat (L + 4) @(negedge rd_clk);
`ifdef FIFO_RD_STREAM_CNT_EN
    check("beat_cnt_total", 64'(beat_cnt), 64'(beat_model));
`endif

    // Reset with words both in flight and buffered
    @(negedge rd_clk);
    rdy_mode = 0;
    @(negedge rd_clk);
    for (int i = 0; i < 8; i++) push_word(8'h40 + 8'(i));
    repeat (L + 2) @(negedge rd_clk);
    #1;
    rst = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    #1;
    check("midrst_rd_en",   64'(rd_en),   64'd0);
    check("midrst_m_valid", 64'(m_valid), 64'd0);
    check("midrst_m_data",  64'(m_data),  64'd0);
`ifdef FIFO_RD_STREAM_CNT_EN
    check("midrst_beat_cnt", 64'(beat_cnt), 64'd0);
`endif
    repeat (3) @(negedge rd_clk);
    @(posedge rd_clk);
    #2 rst = 1'b1;
    rdy_mode = 1;
    @(negedge rd_clk);
    check("post_rst_m_valid", 64'(m_valid), 64'd0);
    for (int i = 0; i < 16; i++) push_word(8'h80 + 8'(i));
    wait_drain(200, "post_rst_drained");
    repeat (L + 4) @(negedge rd_clk);
    check("post_rst_idle_valid", 64'(m_valid), 64'd0);
`ifdef FIFO_RD_STREAM_CNT_EN
    check("post_rst_beat_cnt", 64'(beat_cnt), 64'd16);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
